// File: rtl/column_feeder_pkg.sv
// Shared constants and FSM state type for the column feeder and its line buffer.
// Holds the default geometry, the derived field widths and the state encoding.
package column_feeder_pkg;

  localparam int DEF_BUF_HEIGHT = 8;
  localparam int DEF_BUF_WIDTH  = 34;
  localparam int DEF_MAX_BANDS  = 64;

  localparam int DEF_COL_W  = $clog2(DEF_BUF_WIDTH);
  localparam int DEF_BAND_W = $clog2(DEF_MAX_BANDS) + 1;

  // Narrowest band the downstream window logic can handle.
  localparam int MIN_IMG_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/column_feeder_if.sv
// Upstream column stream: valid/ready handshake carrying one pixel column per beat.
interface column_feeder_if #(
  parameter int HEIGHT = column_feeder_pkg::DEF_BUF_HEIGHT
);

  logic              s_valid;
  logic [HEIGHT-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/column_feeder_counter.sv
// Column/band position tracker: wraps the column count per band, flags the final
// column of the image and registers the band_end strobe alongside the shift.
module column_feeder_counter #(
  parameter int COL_W  = column_feeder_pkg::DEF_COL_W,
  parameter int BAND_W = column_feeder_pkg::DEF_BAND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [COL_W-1:0]  img_width,
  input  logic [BAND_W-1:0] num_bands,
  output logic              last,
  output logic              band_end
);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic              band_end_q, band_end_d;
  logic              col_last;

  assign col_last = (col_q == img_width - COL_W'(1));
  assign last     = col_last && (band_q == num_bands - BAND_W'(1));
  assign band_end = band_end_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    col_d      = col_q;
    band_d     = band_q;
    band_end_d = 1'b0;
    if (clear) begin
      col_d  = '0;
      band_d = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d      = '0;
        band_d     = band_q + BAND_W'(1);
        band_end_d = 1'b1;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      band_q     <= '0;
      band_end_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      band_q     <= band_d;
      band_end_q <= band_end_d;
    end
  end

endmodule

// File: rtl/column_feeder.sv
// Feeds booleanized pixel columns into the line buffer band by band, with stall,
// abort and configuration checking; IDLE/RUN/DONE control with registered outputs.
module column_feeder
  import column_feeder_pkg::*;
#(
  parameter int BUF_HEIGHT = DEF_BUF_HEIGHT,
  parameter int BUF_WIDTH  = DEF_BUF_WIDTH,
  parameter int MAX_BANDS  = DEF_MAX_BANDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(BUF_WIDTH)-1:0] img_width,
  input  logic [$clog2(MAX_BANDS):0]   num_bands,
  column_feeder_if.slave               up,
  input  logic                         stall,
  output logic [BUF_HEIGHT-1:0]        pixel_out,
  output logic                         shift_enable,
  output logic                         band_end,
  output logic                         done,
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int COL_W  = $clog2(BUF_WIDTH);
  localparam int BAND_W = $clog2(MAX_BANDS) + 1;

  feeder_state_e         state_q, state_d;
  logic [COL_W-1:0]      width_q, width_d;
  logic [BAND_W-1:0]     bands_q, bands_d;
  logic [BUF_HEIGHT-1:0] pixel_q, pixel_d;
  logic                  shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  cfg_err_q, cfg_err_d;

  logic cfg_legal, in_run, accept, start_ok, cnt_clear, last;

  assign cfg_legal = (img_width >= COL_W'(MIN_IMG_WIDTH)) &&
                     (img_width <= COL_W'(BUF_WIDTH - 1)) &&
                     (num_bands >= BAND_W'(1)) &&
                     (num_bands <= BAND_W'(MAX_BANDS));

  assign in_run     = (state_q == ST_RUN);
  assign up.s_ready = in_run && !stall && !abort;
  assign accept     = up.s_ready && up.s_valid;
  assign start_ok   = !in_run && start && cfg_legal;
  // Abort clears position too, so a restarted image begins at column 0.
  assign cnt_clear  = start_ok || (in_run && abort);

  column_feeder_counter #(
    .COL_W  (COL_W),
    .BAND_W (BAND_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .advance   (accept),
    .img_width (width_q),
    .num_bands (bands_q),
    .last      (last),
    .band_end  (band_end)
  );

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    bands_d   = bands_q;
    pixel_d   = pixel_q;
    shift_d   = 1'b0;
    done_d    = done_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d   = ST_RUN;
            width_d   = img_width;
            bands_d   = num_bands;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
          end else begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (accept) begin
          pixel_d = up.s_data;
          shift_d = 1'b1;
          if (last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      bands_q   <= '0;
      pixel_q   <= '0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      bands_q   <= bands_d;
      pixel_q   <= pixel_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pixel_out    = pixel_q;
  assign shift_enable = shift_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_column_feeder.sv
// Directed bench for column_feeder: a vector table for a two-band image plus
// hand-written sequences for stall, bad configuration, abort and mid-image reset.
module tb_column_feeder;

  localparam int H  = 8;
  localparam int CW = 6;
  localparam int BW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, stall;
  logic [CW-1:0] img_width;
  logic [BW-1:0] num_bands;
  logic [H-1:0]  pixel_out;
  logic          shift_enable, band_end, done, busy, cfg_err;

  int n_vec  = 0;
  int n_fail = 0;

  column_feeder_if #(.HEIGHT(H)) up ();

  column_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .img_width    (img_width),
    .num_bands    (num_bands),
    .up           (up),
    .stall        (stall),
    .pixel_out    (pixel_out),
    .shift_enable (shift_enable),
    .band_end     (band_end),
    .done         (done),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          valid;
    logic [H-1:0]  data;
    logic          exp_ready;
    logic          exp_shift;
    logic [H-1:0]  exp_pixel;
    logic          exp_band_end;
    logic          exp_done;
    logic          exp_busy;
    logic          exp_cfg_err;
  } vec_t;

  vec_t vecs[$];
  logic [H-1:0] stall_data [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  function automatic vec_t mk(input logic st, input logic v, input logic [H-1:0] d,
                              input logic r, input logic sh, input logic [H-1:0] px,
                              input logic be, input logic dn, input logic bs, input logic ce);
    vec_t x;
    x.start = st; x.valid = v; x.data = d;
    x.exp_ready = r; x.exp_shift = sh; x.exp_pixel = px;
    x.exp_band_end = be; x.exp_done = dn; x.exp_busy = bs; x.exp_cfg_err = ce;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b0; abort = 1'b0; stall = 1'b0;
    up.s_valid = 1'b0; up.s_data = '0;
  endtask

  task automatic do_start(input logic [CW-1:0] w, input logic [BW-1:0] b);
    start = 1'b1; img_width = w; num_bands = b; up.s_valid = 1'b0;
    cycle();
    start = 1'b0;
  endtask

  task automatic feed(input string name, input logic [H-1:0] d, input logic exp_be,
                      input logic exp_dn);
    up.s_valid = 1'b1; up.s_data = d;
    #1;
    check({name, "_ready"}, 32'(up.s_ready), 32'(1'b1));
    cycle();
    check({name, "_shift"}, 32'(shift_enable), 32'(1'b1));
    check({name, "_pixel"}, 32'(pixel_out), 32'(d));
    check({name, "_band_end"}, 32'(band_end), 32'(exp_be));
    check({name, "_done"}, 32'(done), 32'(exp_dn));
    up.s_valid = 1'b0;
  endtask

  task automatic bad_cfg(input string name, input logic [CW-1:0] w, input logic [BW-1:0] b);
    start = 1'b1; img_width = w; num_bands = b; up.s_valid = 1'b1; up.s_data = 8'hAA;
    #1;
    check({name, "_ready_at_start"}, 32'(up.s_ready), 32'(1'b0));
    cycle();
    start = 1'b0;
    check({name, "_cfg_err"}, 32'(cfg_err), 32'(1'b1));
    check({name, "_done"}, 32'(done), 32'(1'b1));
    check({name, "_busy"}, 32'(busy), 32'(1'b0));
    #1;
    check({name, "_ready_after"}, 32'(up.s_ready), 32'(1'b0));
    cycle();
    check({name, "_no_shift"}, 32'(shift_enable), 32'(1'b0));
    up.s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int nshift;
    logic exp_rdy;

    drive_idle();
    img_width = '0; num_bands = '0;
    rst_n = 1'b0;
    #3;
    check("rst_pixel", 32'(pixel_out), 32'(0));
    check("rst_shift", 32'(shift_enable), 32'(0));
    check("rst_band_end", 32'(band_end), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_ready", 32'(up.s_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Two bands of five columns, source always valid.
    vecs.push_back(mk(1, 1, 8'hEE, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hA1, 1, 1, 8'hA1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h5B, 1, 1, 8'h5B, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 8'h3C, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hC4, 1, 1, 8'hC4, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h0F, 1, 1, 8'h0F, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'hF0, 1, 1, 8'hF0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h99, 1, 1, 8'h99, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h66, 1, 1, 8'h66, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h81, 1, 1, 8'h81, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 8'h7E, 1, 1, 8'h7E, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h42, 0, 0, 8'h7E, 0, 1, 0, 0));

    img_width = 6'd5; num_bands = 7'd2;
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; up.s_valid = vecs[i].valid; up.s_data = vecs[i].data;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(up.s_ready), 32'(vecs[i].exp_ready));
      cycle();
      check($sformatf("tbl%0d_shift", i), 32'(shift_enable), 32'(vecs[i].exp_shift));
      check($sformatf("tbl%0d_pixel", i), 32'(pixel_out), 32'(vecs[i].exp_pixel));
      check($sformatf("tbl%0d_band_end", i), 32'(band_end), 32'(vecs[i].exp_band_end));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("tbl%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_cfg_err));
    end
    drive_idle();

    // Stall held for cycles 2..4 of a one-band, four-column image.
    do_start(6'd4, 7'd1);
    idx = 0; nshift = 0;
    for (int c = 1; c <= 10; c++) begin
      stall = (c >= 2 && c <= 4);
      up.s_valid = 1'b1;
      up.s_data = (idx < 4) ? stall_data[idx] : 8'hFF;
      #1;
      exp_rdy = (idx < 4) && !stall;
      check($sformatf("stall_c%0d_ready", c), 32'(up.s_ready), 32'(exp_rdy));
      cycle();
      check($sformatf("stall_c%0d_shift", c), 32'(shift_enable), 32'(exp_rdy));
      if (exp_rdy) idx++;
      if (shift_enable) begin
        if (nshift < 4) check($sformatf("stall_order%0d", nshift), 32'(pixel_out),
                              32'(stall_data[nshift]));
        nshift++;
      end else if (idx > 0 && idx < 4) begin
        check($sformatf("stall_c%0d_hold", c), 32'(pixel_out), 32'(stall_data[idx-1]));
      end
    end
    check("stall_shift_count", 32'(nshift), 32'(4));
    check("stall_done", 32'(done), 32'(1));
    drive_idle();

    // Illegal configurations at both ends of each range.
    bad_cfg("w2", 6'd2, 7'd1);
    bad_cfg("b0", 6'd5, 7'd0);
    bad_cfg("w34", 6'd34, 7'd1);
    bad_cfg("b65", 6'd5, 7'd65);

    // Widest legal band accepted, then aborted.
    do_start(6'd33, 7'd64);
    check("w33_busy", 32'(busy), 32'(1));
    check("w33_cfg_err", 32'(cfg_err), 32'(0));
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("w33_abort_busy", 32'(busy), 32'(0));

    // Abort after three accepts; start+abort in RUN lets abort win.
    do_start(6'd6, 7'd1);
    check("ab_cfg_err_cleared", 32'(cfg_err), 32'(0));
    check("ab_done_cleared", 32'(done), 32'(0));
    feed("ab1", 8'h01, 1'b0, 1'b0);
    feed("ab2", 8'h02, 1'b0, 1'b0);
    feed("ab3", 8'h03, 1'b0, 1'b0);
    abort = 1'b1; start = 1'b1; img_width = 6'd3; num_bands = 7'd1;
    up.s_valid = 1'b1; up.s_data = 8'h04;
    #1;
    check("ab_ready", 32'(up.s_ready), 32'(0));
    cycle();
    check("ab_busy", 32'(busy), 32'(0));
    check("ab_done", 32'(done), 32'(0));
    check("ab_shift", 32'(shift_enable), 32'(0));
    check("ab_pixel_hold", 32'(pixel_out), 32'(8'h03));
    up.s_valid = 1'b0;
    // In IDLE, start with abort must still begin the image.
    cycle();
    abort = 1'b0; start = 1'b0;
    check("ab_restart_busy", 32'(busy), 32'(1));
    feed("rs1", 8'h11, 1'b0, 1'b0);
    feed("rs2", 8'h22, 1'b0, 1'b0);
    feed("rs3", 8'h33, 1'b1, 1'b1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("ab_in_done_ignored", 32'(done), 32'(1));

    // Reset after seven accepts of an 8x2 image, then a full image.
    do_start(6'd8, 7'd2);
    for (int k = 0; k < 7; k++) feed($sformatf("pre%0d", k), H'(8'h50 + k), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_shift", 32'(shift_enable), 32'(0));
    check("arst_pixel", 32'(pixel_out), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_ready", 32'(up.s_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_rst_shift", 32'(shift_enable), 32'(0));
    check("post_rst_band_end", 32'(band_end), 32'(0));
    check("post_rst_done", 32'(done), 32'(0));
    do_start(6'd3, 7'd2);
    for (int k = 0; k < 6; k++)
      feed($sformatf("post%0d", k), H'(8'hC0 + k), (k == 2 || k == 5), (k == 5));
    check("post_busy_end", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
